sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO; next generation of the team's 8-bit/16-deep buffer. Generalised data width and depth. Adds:
- full/empty computed from next-state occupancy, so flags are exact on the same edge as the operation
- occupancy count, programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags, synchronous flush
Sits between producer and consumer blocks in the same clock domain (UART/SPI byte paths, packet staging).

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- Derived constant AW = $clog2(DEPTH); count is AW+1 bits wide.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush; empties FIFO and clears error flags
- wr  in  1  write request
- din  in  WIDTH  write data
- rd  in  1  read request
- dout  out  WIDTH  head-of-queue data (show-ahead)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- parity_err  out  1  read-side parity mismatch (FIFO_PARITY_EN only; constant 0 otherwise)

Behaviour:
- Reset (rst_n low, async):
  - write/read pointers = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - overflow = 0, underflow = 0, parity_err = 0
  - Memory contents are not reset.
- Pointers: AW-bit, wrap naturally from DEPTH-1 to 0. No modulo logic, because DEPTH is a power of two.
- Accept rules, evaluated on registered flags:
  - rd_ok = rd && !empty
  - wr_ok = wr && (!full || rd_ok)
- Write accepted: mem[wr_ptr] <= din; wr_ptr increments.
- Read accepted: rd_ptr increments.
- Read data path:
  - dout = mem[rd_ptr], combinational (show-ahead). It is valid whenever empty = 0, and the read consumes the word already on dout.
  - When empty = 1, dout is don't-care.
- count_next = count + wr_ok - rd_ok. All flags are registered from count_next, so they are exact in the cycle after the edge.
- Simultaneous events:
  - Full with wr and rd: both accepted, count unchanged, full stays 1.
  - Empty with wr and rd: write accepted, read rejected; underflow sets. There is no bypass: the written word appears on dout next cycle.
  - Mid-occupancy with wr and rd: both accepted, count unchanged.
- overflow sets on wr && !wr_ok; underflow sets on rd && !rd_ok. Both hold until clr or reset.
- clr takes priority over wr/rd in the same cycle. Next state is identical to the reset state; a concurrent write is discarded.
- Reset asserted mid-operation: immediate return to the reset state; held data is lost.

Optional Feature:
- Macro FIFO_PARITY_EN.
- Defined:
  - memory is WIDTH+1 bits; writes store even parity of din in the extra bit.
  - On each accepted read, parity of the stored word is checked. parity_err is a registered one-cycle pulse the cycle after a mismatching read.
- Undefined: memory is WIDTH bits and parity_err is tied to 0.

Decomposition:
- Package fifo_pkg holds:
  - function clog2_depth
  - localparam defaults DEF_WIDTH = 8, DEF_DEPTH = 16
  - typedef fifo_status_t, a struct of {full, empty, almost_full, almost_empty, overflow, underflow}, for reuse by wrapper blocks.
- One natural sub-module: fifo_ram, a WIDTH(+1) x DEPTH array with one synchronous write port and one asynchronous read port. Control, pointers, count and flags stay in the top.

Test Plan (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2):
1. Reset then write 0x01..0x10 over 16 cycles:
   - almost_empty drops after the 3rd write
   - almost_full rises after the 14th write
   - full=1 and count=16 after the 16th write
   - reading 16 words returns 0x01..0x10 in order, then empty=1.
2. Full FIFO, wr=1 with rd=0, din=0xAA → overflow=1, count stays 16; the rejected 0xAA is never read out.
3. Full FIFO, wr=1 and rd=1 for 20 cycles with incrementing din → count stays 16, full stays 1; read order is continuous across pointer wrap.
4. Empty FIFO, wr=1 and rd=1, din=0x5C → underflow=1, count=1, dout=0x5C the next cycle.
5. Eight words loaded, assert clr together with wr → count=0, empty=1, overflow/underflow=0; a following write/read returns the new word.
6. With FIFO_PARITY_EN, force-flip one stored bit → parity_err pulses one cycle after that word is read. Without the macro, parity_err stays 0 throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;

    // Status bundle exported to wrapper blocks.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Pointer width for a power-of-two depth.
    function automatic int unsigned clog2_depth(input int unsigned depth);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port; contents not reset.
module fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with occupancy, thresholds and sticky errors.
// Optional read-side parity checking is enabled by defining FIFO_PARITY_EN.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    localparam int unsigned AW      = clog2_depth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow,
    output logic             parity_err
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

    localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                                            almost_empty: 1'b1, overflow: 1'b0,
                                            underflow: 1'b0};

`ifdef FIFO_PARITY_EN
    localparam int unsigned MW = WIDTH + 1;
`else
    localparam int unsigned MW = WIDTH;
`endif

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic          rd_ok;
    logic          wr_ok;
    logic          ram_we;
    logic [MW-1:0] wdata;
    logic [MW-1:0] rdata;
    fifo_status_t  status_q;

    // Accept decisions use the registered flags; a read frees a slot for a write when full.
    always_comb begin
        rd_ok      = rd && !status_q.empty;
        wr_ok      = wr && (!status_q.full || rd_ok);
        count_next = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        ram_we     = wr_ok && !clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            status_q <= STATUS_RST;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            status_q <= STATUS_RST;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count                 <= count_next;
            status_q.full         <= (count_next == FULL_CNT);
            status_q.empty        <= (count_next == '0);
            status_q.almost_full  <= (count_next >= AF_CNT);
            status_q.almost_empty <= (count_next <= AE_CNT);
            status_q.overflow     <= status_q.overflow  | (wr && !wr_ok);
            status_q.underflow    <= status_q.underflow | (rd && !rd_ok);
        end
    end

    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;

`ifdef FIFO_PARITY_EN
    // Extra bit holds even parity so a stored word XORs to zero when intact.
    assign wdata = {^din, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (clr) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_ok && (^rdata);
        end
    end
`else
    assign wdata      = din;
    assign parity_err = 1'b0;
`endif

    assign dout = rdata[WIDTH-1:0];

    fifo_ram #(
        .WIDTH (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model plus directed checks.
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 14;
    localparam int unsigned AE    = 2;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;
    logic             parity_err;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    bit               m_udf;

    sync_fifo_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr           (wr),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy is the queue length, accept rules on current occupancy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit ra;
            bit wa;
            ra = rd && (q.size() > 0);
            wa = wr && ((q.size() < DEPTH) || ra);
            if (rd && !ra) m_udf = 1'b1;
            if (wr && !wa) m_ovf = 1'b1;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(din);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_udf));
`ifndef FIFO_PARITY_EN
            chk("parity_err", 32'(parity_err), 32'd0);
`endif
            if (q.size() > 0) chk("dout", 32'(dout), 32'(q[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input bit r, input logic [WIDTH-1:0] d);
        wr  = w;
        rd  = r;
        din = d;
        step();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
        #22;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_errs", 32'({overflow, underflow, parity_err}), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step();

        // Fill with 0x01..0x10, watching threshold crossings
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b0, WIDTH'(i));
            if (i == 2)  chk("t1_ae_at2", 32'(almost_empty), 32'd1);
            if (i == 3)  chk("t1_ae_at3", 32'(almost_empty), 32'd0);
            if (i == 13) chk("t1_af_at13", 32'(almost_full), 32'd0);
            if (i == 14) chk("t1_af_at14", 32'(almost_full), 32'd1);
        end
        chk("t1_full", 32'(full), 32'd1);
        chk("t1_count", 32'(count), 32'd16);
        chk("t1_model_size", 32'(q.size()), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            chk("t1_rd_data", 32'(dout), 32'(i));
            drive(1'b0, 1'b1, '0);
        end
        chk("t1_empty", 32'(empty), 32'd1);

        // Refill and overflow with 0xAA
        for (int i = 1; i <= 16; i++) drive(1'b1, 1'b0, WIDTH'(32'h20 + i));
        drive(1'b1, 1'b0, 8'hAA);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_count", 32'(count), 32'd16);

        // Full with simultaneous wr/rd across pointer wrap
        for (int k = 0; k < 20; k++) begin
            if (k < 16) chk("t3_dout", 32'(dout), 32'h21 + 32'(k));
            else        chk("t3_dout", 32'(dout), 32'h40 + 32'(k - 16));
            drive(1'b1, 1'b1, WIDTH'(32'h40 + k));
            chk("t3_count", 32'(count), 32'd16);
            chk("t3_full", 32'(full), 32'd1);
        end
        for (int k = 4; k < 20; k++) begin
            chk("t3_drain", 32'(dout), 32'h40 + 32'(k));
            drive(1'b0, 1'b1, '0);
        end
        chk("t3_empty", 32'(empty), 32'd1);

        // Empty with wr+rd: write only, underflow sets
        clr = 1'b1; step(); clr = 1'b0;
        drive(1'b1, 1'b1, 8'h5C);
        chk("t4_underflow", 32'(underflow), 32'd1);
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_dout", 32'(dout), 32'h5C);
        drive(1'b0, 1'b1, '0);

        // Flush with concurrent write
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, WIDTH'(32'h80 + i));
        clr = 1'b1;
        drive(1'b1, 1'b0, 8'h99);
        clr = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_errs", 32'({overflow, underflow}), 32'd0);
        drive(1'b1, 1'b0, 8'h77);
        chk("t5_new_word", 32'(dout), 32'h77);
        drive(1'b0, 1'b1, '0);
        chk("t5_empty2", 32'(empty), 32'd1);

`ifdef FIFO_PARITY_EN
        // Corrupt the stored parity bit of the word at address 0
        clr = 1'b1; step(); clr = 1'b0;
        drive(1'b1, 1'b0, 8'h3C);
        dut.u_ram.mem[0][WIDTH] = ~dut.u_ram.mem[0][WIDTH];
        chk("t6_no_err_yet", 32'(parity_err), 32'd0);
        drive(1'b0, 1'b1, '0);
        chk("t6_parity_pulse", 32'(parity_err), 32'd1);
        step();
        chk("t6_parity_clear", 32'(parity_err), 32'd0);
`endif

        // Randomized traffic with shifting bias and occasional flush
        for (int ph = 0; ph < 8; ph++) begin
            int pw;
            int pr;
            pw = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 20 : 55);
            pr = (ph % 3 == 0) ? 25 : ((ph % 3 == 1) ? 85 : 55);
            for (int c = 0; c < 250; c++) begin
                clr = ($urandom_range(0, 99) == 0);
                drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                      WIDTH'($urandom));
                clr = 1'b0;
            end
        end

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, WIDTH'(i + 1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 8'hE1);
        chk("post_rst_dout", 32'(dout), 32'hE1);
        step();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
